// File: rtl/prio_enc_rr_if.sv
// Request/result bundle for prio_enc_rr: request vector and mode towards the
// encoder, registered winner back to the consumer behind valid/ready.
interface prio_enc_rr_if #(
    parameter int unsigned N = 8
);
    localparam int unsigned IW = $clog2(N);

    logic [N-1:0]  req;
    logic          mode;
    logic          out_ready;
    logic          out_valid;
    logic [IW-1:0] out_idx;
    logic [N-1:0]  out_onehot;

    modport master (
        output req,
        output mode,
        output out_ready,
        input  out_valid,
        input  out_idx,
        input  out_onehot
    );

    modport slave (
        input  req,
        input  mode,
        input  out_ready,
        output out_valid,
        output out_idx,
        output out_onehot
    );
endinterface

// File: rtl/prio_enc_rr.sv
// Registered N-input priority encoder, fixed (highest index wins) or
// round-robin priority, with the result held behind a valid/ready handshake.
module prio_enc_rr #(
    parameter int unsigned N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    prio_enc_rr_if.slave bus
);
    localparam int unsigned    IW      = $clog2(N);
    localparam logic [IW-1:0]  PTR_TOP = IW'(N - 1);

    typedef enum logic {
        MODE_FIXED = 1'b0,
        MODE_RR    = 1'b1
    } mode_e;

    logic          valid_q,  valid_d;
    logic [IW-1:0] idx_q,    idx_d;
    logic [N-1:0]  onehot_q, onehot_d;
    mode_e         tag_q,    tag_d;
    logic [IW-1:0] ptr_q,    ptr_d;

    logic          load;
    logic          accept;
    logic [N-1:0]  low_mask;
    logic [N-1:0]  req_low;
    logic          any_req;
    logic          any_low;
    logic [IW-1:0] top_all;
    logic [IW-1:0] top_low;
    logic [IW-1:0] winner;

    function automatic logic [IW-1:0] highest_set(input logic [N-1:0] v);
        logic [IW-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (v[i]) begin
                r = IW'(i);
            end
        end
        return r;
    endfunction

    assign load   = !valid_q || bus.out_ready;
    assign accept = valid_q && bus.out_ready;

    // Round-robin order ptr..0 then N-1..ptr+1 equals: highest request at or
    // below ptr if any, otherwise highest request overall.
    always_comb begin
        low_mask = '0;
        for (int unsigned i = 0; i < N; i++) begin
            low_mask[i] = (IW'(i) <= ptr_q);
        end
        req_low = bus.req & low_mask;
        any_req = |bus.req;
        any_low = |req_low;
        top_all = highest_set(bus.req);
        top_low = highest_set(req_low);
        if ((mode_e'(bus.mode) == MODE_RR) && any_low) begin
            winner = top_low;
        end else begin
            winner = top_all;
        end
    end

    always_comb begin
        valid_d  = valid_q;
        idx_d    = idx_q;
        onehot_d = onehot_q;
        tag_d    = tag_q;
        ptr_d    = ptr_q;

        // Pointer follows the tag of the result being accepted; the capture
        // below still uses ptr_q, so the two updates do not interact.
        if (accept && (tag_q == MODE_RR)) begin
            ptr_d = (idx_q == '0) ? PTR_TOP : (idx_q - IW'(1));
        end

        if (load) begin
            valid_d  = any_req;
            idx_d    = '0;
            onehot_d = '0;
            tag_d    = MODE_FIXED;
            if (any_req) begin
                idx_d            = winner;
                onehot_d[winner] = 1'b1;
                tag_d            = mode_e'(bus.mode);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q  <= 1'b0;
            idx_q    <= '0;
            onehot_q <= '0;
            tag_q    <= MODE_FIXED;
            ptr_q    <= PTR_TOP;
        end else begin
            valid_q  <= valid_d;
            idx_q    <= idx_d;
            onehot_q <= onehot_d;
            tag_q    <= tag_d;
            ptr_q    <= ptr_d;
        end
    end

    assign bus.out_valid  = valid_q;
    assign bus.out_idx    = idx_q;
    assign bus.out_onehot = onehot_q;
endmodule
